// File: rtl/mpu6050_poll_sequencer.sv
// MPU6050 transaction sequencer: wakes the sensor, then periodically sweeps a register block.
// Optional WHO_AM_I identity read before init is enabled by defining MPU_WHOAMI_CHECK_EN.
module mpu6050_poll_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter logic [7:0] BASE_REG    = 8'h3B,
  parameter int         NUM_READS   = 6,
  parameter int         POLL_DIV    = 100000,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   i2c_enable,
  output logic                   i2c_read_write,
  output logic [6:0]             i2c_address,
  output logic [7:0]             i2c_reg,
  output logic [7:0]             i2c_data_out,
  input  logic                   i2c_done,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_rd_data,
  output logic [8*NUM_READS-1:0] sample_data,
  output logic                   sample_valid,
  output logic                   init_done,
  output logic                   err_flag,
  output logic [7:0]             err_count
);

  localparam int IDX_W = (NUM_READS > 1) ? $clog2(NUM_READS) : 1;
  localparam int DIV_W = $clog2(POLL_DIV + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_READS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] PWR_MGMT_1 = 8'h6B;

  typedef enum logic [3:0] {
    IDLE, INIT_ISSUE, INIT_WAIT, POLL_WAIT, RD_ISSUE, RD_WAIT, PUBLISH
`ifdef MPU_WHOAMI_CHECK_EN
    , ID_ISSUE, ID_WAIT
`endif
  } state_t;

`ifdef MPU_WHOAMI_CHECK_EN
  localparam logic [7:0] WHO_AM_I  = 8'h75;
  localparam logic [7:0] ID_EXPECT = {1'b0, DEV_ADDR[6:1], 1'b0};
  localparam state_t     INIT_ENTRY = ID_ISSUE;
`else
  localparam state_t     INIT_ENTRY = INIT_ISSUE;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [8*NUM_READS-1:0] buf_q, buf_d;
  logic [8*NUM_READS-1:0] sample_q, sample_d;
  logic                   i2c_enable_q, i2c_enable_d;
  logic                   rw_q, rw_d;
  logic [7:0]             reg_q, reg_d;
  logic [7:0]             dout_q, dout_d;
  logic                   sv_q, sv_d;
  logic                   init_done_q, init_done_d;
  logic                   err_flag_q, err_flag_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   err_ev;
  logic                   tmo_hit;
  state_t                 post_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      div_q        <= '0;
      tmo_q        <= '0;
      buf_q        <= '0;
      sample_q     <= '0;
      i2c_enable_q <= 1'b0;
      rw_q         <= 1'b0;
      reg_q        <= 8'h00;
      dout_q       <= 8'h00;
      sv_q         <= 1'b0;
      init_done_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      tmo_q        <= tmo_d;
      buf_q        <= buf_d;
      sample_q     <= sample_d;
      i2c_enable_q <= i2c_enable_d;
      rw_q         <= rw_d;
      reg_q        <= reg_d;
      dout_q       <= dout_d;
      sv_q         <= sv_d;
      init_done_q  <= init_done_d;
      err_flag_q   <= err_flag_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    div_d        = '0;
    tmo_d        = tmo_q;
    buf_d        = buf_q;
    sample_d     = sample_q;
    i2c_enable_d = 1'b0;
    rw_d         = rw_q;
    reg_d        = reg_q;
    dout_d       = dout_q;
    sv_d         = 1'b0;
    init_done_d  = init_done_q;
    err_flag_d   = err_flag_q;
    err_cnt_d    = err_cnt_q;
    err_ev       = 1'b0;
    tmo_hit      = (tmo_q == TMO_LAST);
    // Once a transaction ends, a dropped enable parks the sequencer instead of polling on.
    post_st      = enable ? POLL_WAIT : IDLE;

    case (state_q)
      IDLE: begin
        if (enable) begin
          idx_d   = '0;
          state_d = init_done_q ? RD_ISSUE : INIT_ENTRY;
        end
      end
`ifdef MPU_WHOAMI_CHECK_EN
      ID_ISSUE: begin
        rw_d         = 1'b1;
        reg_d        = WHO_AM_I;
        i2c_enable_d = 1'b1;
        tmo_d        = '0;
        state_d      = ID_WAIT;
      end
      ID_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (i2c_done) begin
          if (!i2c_nack && (i2c_rd_data == ID_EXPECT)) begin
            state_d = enable ? INIT_ISSUE : IDLE;
          end else begin
            err_ev  = 1'b1;
            state_d = post_st;
          end
        end else if (tmo_hit) begin
          err_ev  = 1'b1;
          state_d = post_st;
        end
      end
`endif
      INIT_ISSUE: begin
        rw_d         = 1'b0;
        reg_d        = PWR_MGMT_1;
        dout_d       = 8'h00;
        i2c_enable_d = 1'b1;
        tmo_d        = '0;
        state_d      = INIT_WAIT;
      end
      INIT_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (i2c_done) begin
          if (i2c_nack) err_ev = 1'b1;
          else          init_done_d = 1'b1;
          state_d = post_st;
        end else if (tmo_hit) begin
          err_ev  = 1'b1;
          state_d = post_st;
        end
      end
      POLL_WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (div_q == DIV_LAST) begin
          idx_d   = '0;
          state_d = init_done_q ? RD_ISSUE : INIT_ENTRY;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      RD_ISSUE: begin
        rw_d         = 1'b1;
        reg_d        = BASE_REG + 8'(idx_q);
        i2c_enable_d = 1'b1;
        tmo_d        = '0;
        state_d      = RD_WAIT;
      end
      RD_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (i2c_done && !i2c_nack) begin
          buf_d[8*idx_q +: 8] = i2c_rd_data;
          if (idx_q == IDX_LAST) begin
            state_d = PUBLISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = enable ? RD_ISSUE : IDLE;
          end
        end else if (i2c_done || tmo_hit) begin
          // Partial sweep is abandoned; sample_data keeps the last complete one.
          err_ev  = 1'b1;
          state_d = post_st;
        end
      end
      PUBLISH: begin
        sample_d = buf_q;
        sv_d     = 1'b1;
        state_d  = post_st;
      end
      default: state_d = IDLE;
    endcase

    if (err_ev) begin
      err_flag_d = 1'b1;
      err_cnt_d  = sat_inc(err_cnt_q);
    end
  end

  assign i2c_enable     = i2c_enable_q;
  assign i2c_read_write = rw_q;
  assign i2c_address    = DEV_ADDR;
  assign i2c_reg        = reg_q;
  assign i2c_data_out   = dout_q;
  assign sample_data    = sample_q;
  assign sample_valid   = sv_q;
  assign init_done      = init_done_q;
  assign err_flag       = err_flag_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_mpu6050_poll_sequencer.sv
// Directed bench for mpu6050_poll_sequencer with a small I2C master responder model.
`timescale 1ns/1ps
module tb_mpu6050_poll_sequencer;
  localparam int POLL_DIV    = 20;
  localparam int TIMEOUT_CYC = 40;
  localparam int NUM_READS   = 6;
  localparam int LAT         = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic i2c_enable, i2c_read_write;
  logic [6:0] i2c_address;
  logic [7:0] i2c_reg, i2c_data_out;
  logic i2c_done = 1'b0;
  logic i2c_nack = 1'b0;
  logic [7:0] i2c_rd_data = 8'h00;
  logic [8*NUM_READS-1:0] sample_data;
  logic sample_valid, init_done, err_flag;
  logic [7:0] err_count;

  mpu6050_poll_sequencer #(
    .DEV_ADDR(7'h68), .BASE_REG(8'h3B), .NUM_READS(NUM_READS),
    .POLL_DIV(POLL_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2c_enable(i2c_enable), .i2c_read_write(i2c_read_write),
    .i2c_address(i2c_address), .i2c_reg(i2c_reg), .i2c_data_out(i2c_data_out),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rd_data(i2c_rd_data),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .init_done(init_done), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder knobs, written only by the stimulus block.
  int hang_at   = -1;
  int nack_lo   = -1;
  int nack_hi   = -2;
  int stray_req = 0;

  // Responder state, written only by the responder.
  int pend_cnt  = -1;
  int pend_idx  = 0;
  int stray_ack = 0;
  int txn_n     = 0;
  int sv_cnt    = 0;
  logic       txn_rw  [1024];
  logic [7:0] txn_reg [1024];
  logic [7:0] txn_dat [1024];
  int         txn_cyc [1024];

  always @(negedge clk) begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (reset) begin
      pend_cnt = -1;
    end else if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        i2c_done    = 1'b1;
        i2c_nack    = (pend_idx >= nack_lo) && (pend_idx <= nack_hi);
        i2c_rd_data = 8'(8'h10 + (i2c_reg - 8'h3B));
        pend_cnt    = -1;
      end
    end
    if (stray_req != stray_ack) begin
      stray_ack   = stray_req;
      i2c_done    = 1'b1;
      i2c_rd_data = 8'hEE;
    end
    if (i2c_enable) begin
      if (txn_n < 1024) begin
        txn_rw[txn_n]  = i2c_read_write;
        txn_reg[txn_n] = i2c_reg;
        txn_dat[txn_n] = i2c_data_out;
        txn_cyc[txn_n] = cyc;
      end
      if (txn_n != hang_at) begin
        pend_cnt = LAT;
        pend_idx = txn_n;
      end
      txn_n = txn_n + 1;
    end
    if (sample_valid) sv_cnt = sv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_txn(input int n, input int budget);
    int i = 0;
    while (txn_n < n && i < budget) begin step(1); i++; end
    chk("wait_txn", 64'(txn_n >= n), 64'd1);
  endtask

  task automatic wait_sv(input int n, input int budget);
    int i = 0;
    while (sv_cnt < n && i < budget) begin step(1); i++; end
    chk("wait_sample_valid", 64'(sv_cnt >= n), 64'd1);
  endtask

  task automatic wait_err_change(input logic [7:0] prev, input int budget);
    int i = 0;
    while (err_count == prev && i < budget) begin step(1); i++; end
    chk("wait_err", 64'(err_count != prev), 64'd1);
  endtask

  task automatic wait_init(input int budget);
    int i = 0;
    while (!init_done && i < budget) begin step(1); i++; end
    chk("wait_init_done", 64'(init_done), 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_i2c_enable"}, 64'(i2c_enable), 64'd0);
    chk({tag, "_rw"}, 64'(i2c_read_write), 64'd0);
    chk({tag, "_addr"}, 64'(i2c_address), 64'h68);
    chk({tag, "_reg"}, 64'(i2c_reg), 64'h00);
    chk({tag, "_dout"}, 64'(i2c_data_out), 64'h00);
    chk({tag, "_sample"}, 64'(sample_data), 64'h0);
    chk({tag, "_svalid"}, 64'(sample_valid), 64'd0);
    chk({tag, "_init_done"}, 64'(init_done), 64'd0);
    chk({tag, "_err_flag"}, 64'(err_flag), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // Reset state
    step(3);
    chk_reset_outs("reset");

    // Test 1: init write then one full sweep
    reset = 1'b0;
    enable = 1'b1;
    wait_txn(1, 50);
    chk("t1_init_rw", 64'(txn_rw[0]), 64'd0);
    chk("t1_init_reg", 64'(txn_reg[0]), 64'h6B);
    chk("t1_init_data", 64'(txn_dat[0]), 64'h00);
    wait_init(20);
    wait_txn(7, 200);
    chk("t1_poll_gap", 64'(txn_cyc[1] - txn_cyc[0]), 64'(POLL_DIV + 5));
    chk("t1_read_gap", 64'(txn_cyc[2] - txn_cyc[1]), 64'd5);
    for (int k = 0; k < NUM_READS; k++) begin
      chk($sformatf("t1_rd%0d_rw", k), 64'(txn_rw[1+k]), 64'd1);
      chk($sformatf("t1_rd%0d_reg", k), 64'(txn_reg[1+k]), 64'(8'h3B + k));
    end
    wait_sv(1, 50);
    step(2);
    chk("t1_sample", 64'(sample_data), 64'h151413121110);
    chk("t1_sv_cnt", 64'(sv_cnt), 64'd1);
    chk("t1_no_err", 64'(err_flag), 64'd0);

    // Test 3: third read of the second sweep never completes
    hang_at = 9;
    wait_txn(10, 200);
    t0 = txn_cyc[9];
    chk("t3_hang_reg", 64'(txn_reg[9]), 64'h3D);
    wait_err_change(8'd0, 200);
    chk("t3_timeout_cycles", 64'(cyc - t0), 64'(TIMEOUT_CYC));
    chk("t3_err_count", 64'(err_count), 64'd1);
    chk("t3_err_flag", 64'(err_flag), 64'd1);
    chk("t3_no_sv", 64'(sv_cnt), 64'd1);
    chk("t3_sample_kept", 64'(sample_data), 64'h151413121110);
    wait_txn(11, 100);
    chk("t3_restart_reg", 64'(txn_reg[10]), 64'h3B);
    chk("t3_restart_gap", 64'(txn_cyc[10] - txn_cyc[9]), 64'(TIMEOUT_CYC + POLL_DIV + 1));
    wait_sv(2, 200);
    chk("t3_sweep2_sample", 64'(sample_data), 64'h151413121110);

    // Test 4: enable dropped during the 4th read of the third sweep
    wait_txn(20, 200);
    enable = 1'b0;
    chk("t4_4th_reg", 64'(txn_reg[19]), 64'h3E);
    step(60);
    chk("t4_no_more_issue", 64'(txn_n), 64'd20);
    chk("t4_no_sv", 64'(sv_cnt), 64'd2);
    chk("t4_err_unchanged", 64'(err_count), 64'd1);
    enable = 1'b1;
    t0 = cyc;
    wait_txn(21, 20);
    chk("t4_reenable_rw", 64'(txn_rw[20]), 64'd1);
    chk("t4_reenable_reg", 64'(txn_reg[20]), 64'h3B);
    chk("t4_reenable_lat", 64'(txn_cyc[20] - t0), 64'd2);
    wait_sv(3, 200);
    chk("t4_init_kept", 64'(init_done), 64'd1);

    // Test 6: reset mid RD_WAIT, then a stray done while idle
    wait_txn(27, 200);
    chk("t6_rd_reg", 64'(txn_reg[26]), 64'h3B);
    step(1);
    reset = 1'b1;
    enable = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    chk_reset_outs("t6_reset");
    stray_req = stray_req + 1;
    step(5);
    chk_reset_outs("t6_stray");
    chk("t6_no_issue", 64'(txn_n), 64'd27);

    // Test 2: first init write after re-enable is NACKed, retry succeeds
    nack_lo = 27;
    nack_hi = 27;
    enable = 1'b1;
    wait_txn(28, 20);
    chk("t2_init_rw", 64'(txn_rw[27]), 64'd0);
    chk("t2_init_reg", 64'(txn_reg[27]), 64'h6B);
    wait_err_change(8'd0, 50);
    chk("t2_err_flag", 64'(err_flag), 64'd1);
    chk("t2_err_count", 64'(err_count), 64'd1);
    chk("t2_init_done0", 64'(init_done), 64'd0);
    wait_txn(29, 100);
    chk("t2_retry_rw", 64'(txn_rw[28]), 64'd0);
    chk("t2_retry_reg", 64'(txn_reg[28]), 64'h6B);
    chk("t2_retry_gap", 64'(txn_cyc[28] - txn_cyc[27]), 64'(POLL_DIV + 5));
    wait_init(20);
    chk("t2_err_after_ack", 64'(err_count), 64'd1);

    // Test 5: 260 NACKed reads saturate the error counter
    nack_lo = 29;
    nack_hi = 29 + 259;
    wait_txn(29 + 260, 20000);
    step(10);
    chk("t5_err_sat", 64'(err_count), 64'd255);
    chk("t5_err_flag", 64'(err_flag), 64'd1);
    chk("t5_reg_last", 64'(txn_reg[29 + 259]), 64'h3B);
    chk("t5_sv_none", 64'(sv_cnt), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu6050_poll_sequencer.md
Name: mpu6050_poll_sequencer

Overview:
Transaction sequencer that sits above the I2C byte-level master and drives its enable/read_write/address/register/data inputs.
- After enable, it initialises the MPU6050 by writing PWR_MGMT_1 = 0x00.
- It then periodically reads NUM_READS consecutive registers starting at BASE_REG.
- Each completed sweep is published as one packed sample word with a 1-cycle valid strobe.
- Failed transactions (NACK or timeout) are counted and recovered from automatically.

Parameters:
DEV_ADDR, 7'h68, 7-bit slave address driven on i2c_address
BASE_REG, 8'h3B, first register of each poll sweep (ACCEL_XOUT_H)
NUM_READS, 6, registers per sweep (1..16)
POLL_DIV, 100000, clk cycles from end of one sweep to start of the next (>=1)
TIMEOUT_CYC, 4096, max clk cycles from i2c_enable pulse to i2c_done before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = run sequencer, 0 = stop after the current transaction
i2c_enable  out  1  1-cycle start pulse to the master
i2c_read_write  out  1  1 = read, 0 = write; stable while transaction in flight
i2c_address  out  7  always DEV_ADDR
i2c_reg  out  8  target register; stable while in flight
i2c_data_out  out  8  write byte; stable while in flight
i2c_done  in  1  1-cycle pulse from the master: transaction finished
i2c_nack  in  1  valid only with i2c_done; 1 = slave NACKed
i2c_rd_data  in  8  read byte; valid with i2c_done when i2c_read_write = 1
sample_data  out  8*NUM_READS  last complete sweep; byte k (register BASE_REG+k) at bits [8k+7:8k]
sample_valid  out  1  1-cycle pulse when sample_data updates
init_done  out  1  high once the PWR_MGMT_1 write has been ACKed
err_flag  out  1  sticky; set on any NACK or timeout, cleared only by reset
err_count  out  8  error count, saturates at 255

Behaviour:
- Reset (synchronous): state IDLE, all outputs 0 except i2c_address = DEV_ADDR; internal buffer, divider, index and timeout counters cleared. A reset during an in-flight transaction abandons it; a late i2c_done in IDLE is ignored.
- States: IDLE, INIT_ISSUE, INIT_WAIT, POLL_WAIT, RD_ISSUE, RD_WAIT, PUBLISH.
- IDLE:
  - enable=1 and init_done=0 -> INIT_ISSUE.
  - enable=1 and init_done=1 -> RD_ISSUE.
- INIT_ISSUE: drive rw=0, reg=8'h6B, data=8'h00, pulse i2c_enable for one cycle -> INIT_WAIT.
- INIT_WAIT:
  - i2c_done with nack=0 -> set init_done -> POLL_WAIT.
  - i2c_done with nack=1, or timeout -> error -> POLL_WAIT with init_done still 0. Init is retried after the divider expires.
- POLL_WAIT:
  - The divider counts POLL_DIV cycles.
  - On expiry: init_done=0 -> INIT_ISSUE; otherwise index=0 -> RD_ISSUE.
  - enable=0 -> IDLE immediately; divider is cleared.
- RD_ISSUE: rw=1, reg=BASE_REG+index (8-bit wrap), pulse i2c_enable -> RD_WAIT.
- RD_WAIT:
  - i2c_done with nack=0: buffer[index] <= i2c_rd_data.
    - If index = NUM_READS-1 -> PUBLISH.
    - Otherwise index+1 and -> RD_ISSUE.
  - NACK or timeout: error, discard the partial sweep (sample_data unchanged) -> POLL_WAIT.
- PUBLISH: copy buffer to sample_data, pulse sample_valid for 1 cycle -> POLL_WAIT (or IDLE if enable=0).
- Latency: i2c_enable for the next read is exactly 2 cycles after the i2c_done that completed the previous read.
- Timeout counter:
  - Cleared on each i2c_enable, increments in the *_WAIT states.
  - Reaching TIMEOUT_CYC counts as an error.
  - If i2c_done and timeout coincide in the same cycle, done wins.
- Error action: err_flag <= 1; err_count increments unless already 255.
- enable=0 while in *_ISSUE or *_WAIT: the current transaction finishes (done or timeout), then -> IDLE with no further issue. Its result is still stored, and PUBLISH still occurs if it was the last read.
- i2c_done outside the *_WAIT states is ignored.

Optional Feature:
MPU_WHOAMI_CHECK_EN
- Defined:
  - Before the init write, the sequencer reads reg 8'h75 (WHO_AM_I) via states ID_ISSUE/ID_WAIT.
  - The value must equal {1'b0, DEV_ADDR[6:1], 1'b0} (0x68 for the default address). A mismatch is treated as an error, and init_done stays 0.
  - Retry follows the same path as a failed init.
- Not defined: no ID states exist; IDLE goes directly to INIT_ISSUE.

Test Plan:
1. Reset, enable=1, model ACKs everything, rd_data = 0x10+k for the k-th read. Required:
   - First i2c_enable has rw=0, reg=0x6B, data=0x00.
   - After POLL_DIV cycles, six reads to regs 0x3B..0x40.
   - sample_data = 0x151413121110 with one sample_valid pulse.
2. NACK on the init write. Required:
   - err_flag=1, err_count=1, init_done=0.
   - The init write is reissued after POLL_DIV cycles; an ACK then sets init_done=1.
3. Model never asserts done on the 3rd read of a sweep. Required:
   - Timeout after TIMEOUT_CYC cycles; err_count increments; no sample_valid.
   - sample_data keeps the previous sweep.
   - The next sweep restarts at reg 0x3B.
4. enable dropped during the 4th read's WAIT. Required:
   - That read completes; no further i2c_enable; state IDLE.
   - Re-enable -> reads start at 0x3B without re-init.
5. Force 260 NACKs. Required: err_count saturates at 255.
6. Reset asserted mid-RD_WAIT, then a stray i2c_done pulse. Required:
   - All outputs at reset values; the stray done is ignored.
   - The init write is issued again after enable.
